// File: rtl/bit_index_scanner.sv
// rtl/bit_index_scanner.sv - emits the index of each set bit of a word, LSB first, one per beat
module bit_index_scanner #(
    parameter int WIDTH = 64,
    parameter int IDX_W = 6,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opa,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [CNT_W-1:0] out_ord,
    output logic             out_last,
    output logic             out_empty
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0] ord_q, ord_d;

    logic [IDX_W-1:0] low_idx;
    logic [WIDTH-1:0] work_cleared;
    logic             one_or_none;

    // Scanning down from the MSB lets the lowest set bit win.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (work_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign work_cleared = work_q & (work_q - WIDTH'(1));
    assign one_or_none  = (work_cleared == '0);

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        ord_d     = ord_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_index = '0;
        out_ord   = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = opa;
                    ord_d   = CNT_W'(1);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_index = low_idx;
                out_ord   = ord_q;
                out_last  = one_or_none;
                out_empty = (work_q == '0);
                if (out_ready) begin
                    work_d = work_cleared;
                    ord_d  = ord_q + CNT_W'(1);
                    if (one_or_none) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            ord_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            ord_q   <= ord_d;
        end
    end

endmodule

// File: tb/tb_bit_index_scanner.sv
// tb/tb_bit_index_scanner.sv - scoreboard bench for bit_index_scanner
module tb_bit_index_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] opa;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_index;
    logic [6:0]  out_ord;
    logic        out_last;
    logic        out_empty;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        int idx;
        int ord;
        bit last;
        bit empty;
    } beat_t;

    beat_t exp_q[$];

    always #5 clk = ~clk;

    bit_index_scanner #(.WIDTH(64), .IDX_W(6), .CNT_W(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opa       (opa),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_ord   (out_ord),
        .out_last  (out_last),
        .out_empty (out_empty)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: one beat per set bit in ascending position order; a zero word gives one empty beat.
    task automatic push_model(input logic [63:0] w);
        int total;
        int n;
        total = 0;
        for (int i = 0; i < 64; i++) total += int'(w[i]);
        if (total == 0) begin
            exp_q.push_back('{idx: 0, ord: 1, last: 1'b1, empty: 1'b1});
        end else begin
            n = 0;
            for (int i = 0; i < 64; i++) begin
                if (w[i]) begin
                    n++;
                    exp_q.push_back('{idx: i, ord: n, last: (n == total), empty: 1'b0});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_beat index=%0d ord=%0d", out_index, out_ord);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_index", out_index, b.idx);
                    check("beat_ord", out_ord, b.ord);
                    check("beat_last", out_last, b.last);
                    check("beat_empty", out_empty, b.empty);
                end
            end else if (!out_valid) begin
                check("idle_outputs_zero", {out_index, out_ord, out_last, out_empty}, 0);
            end
        end
    end

    // Called at posedge+1 with the block idle. mode: 0 ready high, 1 random ready, 2 first beat stalled 3 cycles.
    task automatic send(input logic [63:0] w, input int mode);
        int guard;
        int cyc;
        int total;
        bit accepted;
        total = 0;
        for (int i = 0; i < 64; i++) total += int'(w[i]);
        opa      = w;
        in_valid = 1'b1;
        guard    = 0;
        accepted = 1'b0;
        while (!accepted && guard < 200) begin
            @(negedge clk);
            accepted = in_ready;
            if (!accepted) begin
                @(posedge clk); #1;
            end
            guard++;
        end
        if (!accepted) begin
            n_checks++;
            n_fails++;
            $display("FAIL accept_timeout");
            in_valid = 1'b0;
            return;
        end
        push_model(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
        opa      = {$urandom, $urandom};
        cyc      = 0;
        forever begin
            case (mode)
                1:       out_ready = 1'($urandom % 2);
                2:       out_ready = (cyc >= 3);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            if (in_ready) break;
            if (mode == 2 && cyc < 3) begin
                check("stall_valid", out_valid, 1);
                check("stall_index", out_index, 0);
                check("stall_ord", out_ord, 1);
                check("stall_last", out_last, 0);
            end
            cyc++;
            if (cyc > 2000) begin
                n_checks++;
                n_fails++;
                $display("FAIL emit_timeout cycles=%0d", cyc);
                break;
            end
            @(posedge clk); #1;
        end
        if (mode == 0) check("emit_cycles", cyc, (total == 0) ? 1 : total);
        if (mode == 2) check("emit_cycles_stall", cyc, total + 3);
        check("queue_drained", exp_q.size(), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        logic [63:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        opa       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {out_index, out_ord, out_last, out_empty}, 0);
        @(posedge clk); #1;

        send(64'h0000_0000_0000_0012, 0);
        send(64'h0, 0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 0);
        send(64'h8000_0000_0000_0001, 2);

        // Reset lands while the second beat of 0xF0 is on the output.
        opa      = 64'h0000_0000_0000_00F0;
        in_valid = 1'b1;
        @(negedge clk);
        check("rst_test_accept", in_ready, 1);
        push_model(64'h0000_0000_0000_00F0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_beat2_index", out_index, 5);
        check("rst_beat2_ord", out_ord, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        send(64'h4, 0);

        // Back-to-back offers with in_valid held high.
        opa      = 64'h3;
        in_valid = 1'b1;
        @(negedge clk);
        check("b2b_accept_first", in_ready, 1);
        push_model(64'h3);
        @(posedge clk); #1;
        opa = 64'h8;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (in_ready || cyc > 200) break;
            cyc++;
            @(posedge clk); #1;
        end
        check("b2b_gap_cycles", cyc, 2);
        push_model(64'h8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (in_ready || cyc > 200) break;
            cyc++;
            @(posedge clk); #1;
        end
        check("b2b_second_cycles", cyc, 1);
        check("b2b_drained", exp_q.size(), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 30; k++) begin
            case ($urandom % 4)
                0:       w = 64'h0;
                1:       w = {$urandom, $urandom};
                2:       w = (64'h1 << ($urandom % 64)) | (64'h1 << ($urandom % 64));
                default: w = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            send(w, (k % 2 == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
